i2c_slave_core: RTL and testbench

// Synthesizable I2C slave (responder) with an internal byte register file; the far end of i2c_master_top on the SCL/SDA bus.

---
 rtl/i2c_slave_core_pkg.sv | 31 +++
 rtl/i2c_slave_core_linefilt.sv | 61 ++++++
 rtl/i2c_slave_core.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_core_pkg.sv
// Shared definitions for the I2C slave core.
// Holds the protocol FSM state type and the SDA / R-W bit values used by the
// slave, so the top level and any future sub-blocks agree on the encodings.
// No ports; imported with "import i2c_slave_core_pkg::*".
package i2c_slave_core_pkg;

   // Protocol states of the slave: address phase, memory-pointer phase,
   // write-data phase and read-data phase, each followed by its ACK slot.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_DEV_ACK,
      ST_MEM_ADDR,
      ST_MEM_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } slaveState_t;

   // An ACK is a low SDA level in the ninth clock; a NACK leaves SDA high.
   // These values double as SDA output-enable levels: enable low pulls SDA
   // down (ACK), enable high releases it (NACK / idle).
   localparam logic SDA_ACK  = 1'b0;
   localparam logic SDA_NACK = 1'b1;

   // Eighth bit of the device address byte: 1 requests a read.
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_core_linefilt.sv
// Line conditioner for the I2C slave.
// Brings the asynchronous SCL and SDA pad levels into the clock domain with
// a two-flop synchronizer and derives single-cycle event pulses from the
// synchronized levels.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   sclPad       : raw SCL pad level
//   sdaPad       : raw SDA pad level
//   sdaLevel     : synchronized SDA level, aligned with the event pulses
//   sclRise      : SCL rising edge (data sample point)
//   sclFall      : SCL falling edge (start of SDA hold window)
//   startDet     : SDA fell while SCL was high (START / repeated START)
//   stopDet      : SDA rose while SCL was high (STOP)
module i2c_slave_core_linefilt (
   input  logic clock,
   input  logic reset,
   input  logic sclPad,
   input  logic sdaPad,
   output logic sdaLevel,
   output logic sclRise,
   output logic sclFall,
   output logic startDet,
   output logic stopDet
);

   logic sclMeta, sclSync, sclLast;
   logic sdaMeta, sdaSync, sdaLast;

   // Two synchronizer stages per line plus one history stage for edge
   // detection. Everything resets to the idle-bus level (high) so leaving
   // reset on a quiet bus produces no spurious edges.
   always_ff @(posedge clock) begin
      if (reset) begin
         sclMeta <= 1'b1;
         sclSync <= 1'b1;
         sclLast <= 1'b1;
         sdaMeta <= 1'b1;
         sdaSync <= 1'b1;
         sdaLast <= 1'b1;
      end else begin
         sclMeta <= sclPad;
         sclSync <= sclMeta;
         sclLast <= sclSync;
         sdaMeta <= sdaPad;
         sdaSync <= sdaMeta;
         sdaLast <= sdaSync;
      end
   end

   // START and STOP require SCL to have been high both before and after the
   // SDA transition, so an SDA change racing an SCL edge is not taken as a
   // bus condition.
   always_comb begin
      sdaLevel = sdaSync;
      sclRise  = sclSync & ~sclLast;
      sclFall  = ~sclSync & sclLast;
      startDet = sdaLast & ~sdaSync & sclSync & sclLast;
      stopDet  = ~sdaLast & sdaSync & sclSync & sclLast;
   end

endmodule

// File: rtl/i2c_slave_core.sv
// I2C slave with a small byte register file.
// Receives its 7-bit device address, an optional memory pointer byte and
// write data, or returns register contents for reads. SDA is driven open-
// drain through SdaPadEn; SCL is never driven, so there is no stretching.
// Ports:
//   Clk, Rst            : system clock, synchronous active-high reset
//   SclPadIn, SdaPadIn  : asynchronous bus line levels
//   SdaPadOut           : constant 0, the value driven when enabled
//   SdaPadEn            : active-low SDA drive enable (0 pulls SDA low)
//   LocAddr / LocDout   : local combinational register read port
//   WrStrb/WrAddr/WrData: one-cycle notification of a byte written over I2C
//   Busy                : high between START and STOP
module i2c_slave_core
   import i2c_slave_core_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h10,
   parameter int         DEPTH    = 4,
   parameter int         AWIDTH   = 2,
   parameter bit         WR_BURST = 1'b0,
   parameter bit         RD_BURST = 1'b1,
   parameter int         HOLD_CYC = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              SclPadIn,
   input  logic              SdaPadIn,
   output logic              SdaPadOut,
   output logic              SdaPadEn,
   input  logic [AWIDTH-1:0] LocAddr,
   output logic [7:0]        LocDout,
   output logic              WrStrb,
   output logic [AWIDTH-1:0] WrAddr,
   output logic [7:0]        WrData,
   output logic              Busy
);

   localparam int HOLD_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

   slaveState_t       state, nextState;
   logic              sdaSync, sclRise, sclFall, startDet, stopDet;
   logic [3:0]        bitCnt;
   logic [6:0]        rxShift;
   logic [7:0]        rxByte;
   logic [7:0]        txShift;
   logic [AWIDTH-1:0] pointer;
   logic [HOLD_W-1:0] holdCnt;
   logic              sdaEnTarget;
   logic              addrInRange;
   logic [7:0]        regFile [DEPTH];

   // Pointer advance with wrap at the end of the register file, so depths
   // that are not a power of two still wrap to zero.
   function automatic logic [AWIDTH-1:0] incPtr(input logic [AWIDTH-1:0] p);
      return (p == AWIDTH'(DEPTH - 1)) ? '0 : p + AWIDTH'(1);
   endfunction

   i2c_slave_core_linefilt uLineFilt (
      .clock    (Clk),
      .reset    (Rst),
      .sclPad   (SclPadIn),
      .sdaPad   (SdaPadIn),
      .sdaLevel (sdaSync),
      .sclRise  (sclRise),
      .sclFall  (sclFall),
      .startDet (startDet),
      .stopDet  (stopDet)
   );

   // The byte being completed on this SCL rise: seven bits already shifted
   // plus the bit on the line right now.
   always_comb begin
      rxByte      = {rxShift, sdaSync};
      addrInRange = (rxByte < 8'(DEPTH));
   end

   // State register. START and STOP override everything in the next-state
   // logic, so this block only needs the reset.
   always_ff @(posedge Clk) begin
      if (Rst)
         state <= ST_IDLE;
      else
         state <= nextState;
   end

   // Next-state logic. All protocol progress happens on SCL rising edges;
   // a data phase ends on its eighth rise and an ACK slot on its ninth.
   // Address or pointer mismatches park the FSM in WAIT_STOP, which only a
   // new START or a STOP can leave.
   always_comb begin
      nextState = state;
      if (startDet)
         nextState = ST_DEV_ADDR;
      else if (stopDet)
         nextState = ST_IDLE;
      else if (sclRise) begin
         case (state)
            ST_DEV_ADDR:
               if (bitCnt == 4'd7)
                  nextState = (rxByte[7:1] == I2C_ADDR) ? ST_DEV_ACK : ST_WAIT_STOP;
            ST_DEV_ACK:
               nextState = (rxShift[0] == RW_READ) ? ST_RD_DATA : ST_MEM_ADDR;
            ST_MEM_ADDR:
               if (bitCnt == 4'd7)
                  nextState = addrInRange ? ST_MEM_ACK : ST_WAIT_STOP;
            ST_MEM_ACK:
               nextState = ST_WR_DATA;
            ST_WR_DATA:
               if (bitCnt == 4'd7)
                  nextState = ST_WR_ACK;
            ST_WR_ACK:
               nextState = WR_BURST ? ST_WR_DATA : ST_MEM_ADDR;
            ST_RD_DATA:
               if (bitCnt == 4'd7)
                  nextState = ST_RD_ACK;
            ST_RD_ACK:
               nextState = (sdaSync == SDA_ACK) ? ST_RD_DATA : ST_WAIT_STOP;
            default: ;
         endcase
      end
   end

   // Output decode: the SDA level the slave wants for the current bit slot.
   // It only reaches the pad at the end of the hold window after SCL falls.
   always_comb begin
      sdaEnTarget = SDA_NACK;
      case (state)
         ST_DEV_ACK, ST_MEM_ACK, ST_WR_ACK: sdaEnTarget = SDA_ACK;
         ST_RD_DATA:                        sdaEnTarget = txShift[7];
         default:                           sdaEnTarget = SDA_NACK;
      endcase
   end

   // Datapath: bit counter, receive/transmit shifters, pointer, SDA hold
   // timer and the write notification. A read byte is loaded on the SCL rise
   // that ends the preceding ACK slot; the transmit shifter moves on every
   // rise, but the pad keeps showing the old bit until the hold window after
   // the following fall expires.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         bitCnt   <= '0;
         rxShift  <= '0;
         txShift  <= '0;
         pointer  <= '0;
         holdCnt  <= '0;
         SdaPadEn <= 1'b1;
         WrStrb   <= 1'b0;
         WrAddr   <= '0;
         WrData   <= '0;
      end else begin
         WrStrb <= 1'b0;

         if (sclFall)
            holdCnt <= HOLD_W'(HOLD_CYC);
         else if (holdCnt != '0)
            holdCnt <= holdCnt - 1'b1;

         if (startDet || stopDet)
            SdaPadEn <= 1'b1;
         else if (holdCnt == HOLD_W'(1))
            SdaPadEn <= sdaEnTarget;

         if (startDet || stopDet)
            bitCnt <= '0;
         else if (sclRise) begin
            case (state)
               ST_DEV_ADDR, ST_MEM_ADDR, ST_WR_DATA: begin
                  rxShift <= rxByte[6:0];
                  bitCnt  <= (bitCnt == 4'd7) ? 4'd8 : bitCnt + 4'd1;
                  if (bitCnt == 4'd7 && state == ST_MEM_ADDR && addrInRange)
                     pointer <= rxByte[AWIDTH-1:0];
                  if (bitCnt == 4'd7 && state == ST_WR_DATA) begin
                     WrStrb <= 1'b1;
                     WrAddr <= pointer;
                     WrData <= rxByte;
                     if (WR_BURST)
                        pointer <= incPtr(pointer);
                  end
               end
               ST_DEV_ACK: begin
                  bitCnt <= '0;
                  if (rxShift[0] == RW_READ)
                     txShift <= regFile[pointer];
               end
               ST_RD_DATA: begin
                  txShift <= {txShift[6:0], 1'b0};
                  bitCnt  <= (bitCnt == 4'd7) ? 4'd8 : bitCnt + 4'd1;
               end
               ST_RD_ACK: begin
                  bitCnt <= '0;
                  if (sdaSync == SDA_ACK) begin
                     if (RD_BURST) begin
                        pointer <= incPtr(pointer);
                        txShift <= regFile[incPtr(pointer)];
                     end else
                        txShift <= regFile[pointer];
                  end
               end
               default:
                  bitCnt <= '0;
            endcase
         end
      end
   end

   // Register file. The write is committed from the registered strobe, so
   // during the strobe cycle the local read port still shows the old byte
   // and the new byte appears one cycle later.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++)
            regFile[i] <= 8'h00;
      end else if (WrStrb)
         regFile[WrAddr] <= WrData;
   end

   // Static outputs: open-drain value, local read port and bus activity.
   always_comb begin
      SdaPadOut = 1'b0;
      LocDout   = regFile[LocAddr];
      Busy      = (state != ST_IDLE);
   end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core. Two slaves share one bit-banged bus:
// dut0 at 7'h10 (pointer/data alternate on writes, burst reads) and dut1 at
// 7'h22 (burst writes, fixed-pointer reads). The master is modelled by
// tasks that move SCL/SDA on negative clock edges.
module tb_i2c_slave_core;

   localparam int QTR = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sclDrv = 1'b1;
   logic       sdaDrv = 1'b1;
   logic       sdaLine;
   logic       SdaPadOut0, SdaPadEn0, WrStrb0, Busy0;
   logic       SdaPadOut1, SdaPadEn1, WrStrb1, Busy1;
   logic [1:0] LocAddr0 = 2'd0, LocAddr1 = 2'd0, WrAddr0, WrAddr1;
   logic [7:0] LocDout0, LocDout1, WrData0, WrData1;

   int         assertCnt = 0;
   int         failCnt   = 0;
   int         strbCnt0  = 0;
   int         strbCnt1  = 0;
   int         driveCnt  = 0;
   int         capIdx    = 0;
   bit         capNext   = 1'b0;
   logic [1:0] strbAddr0 [8];
   logic [7:0] strbData0 [8];
   logic [7:0] locNow0   [8];
   logic [7:0] locNext0  [8];

   logic       ack;
   logic [7:0] rd;
   int         snap0, snap1, snapDrv;

   always #5 clock = ~clock;

   assign sdaLine = sdaDrv & (SdaPadEn0 | SdaPadOut0) & (SdaPadEn1 | SdaPadOut1);

   i2c_slave_core #(.I2C_ADDR(7'h10), .DEPTH(4), .AWIDTH(2), .WR_BURST(1'b0),
                    .RD_BURST(1'b1), .HOLD_CYC(2)) dut0 (
      .Clk(clock), .Rst(reset), .SclPadIn(sclDrv), .SdaPadIn(sdaLine),
      .SdaPadOut(SdaPadOut0), .SdaPadEn(SdaPadEn0), .LocAddr(LocAddr0),
      .LocDout(LocDout0), .WrStrb(WrStrb0), .WrAddr(WrAddr0),
      .WrData(WrData0), .Busy(Busy0)
   );

   i2c_slave_core #(.I2C_ADDR(7'h22), .DEPTH(4), .AWIDTH(2), .WR_BURST(1'b1),
                    .RD_BURST(1'b0), .HOLD_CYC(2)) dut1 (
      .Clk(clock), .Rst(reset), .SclPadIn(sclDrv), .SdaPadIn(sdaLine),
      .SdaPadOut(SdaPadOut1), .SdaPadEn(SdaPadEn1), .LocAddr(LocAddr1),
      .LocDout(LocDout1), .WrStrb(WrStrb1), .WrAddr(WrAddr1),
      .WrData(WrData1), .Busy(Busy1)
   );

   // Records write strobes, the local read value during and after the first
   // strobes, and how many cycles any slave pulls SDA low.
   always @(negedge clock) begin
      if (capNext) begin
         locNext0[capIdx] = LocDout0;
         capNext = 1'b0;
      end
      if (WrStrb0) begin
         if (strbCnt0 < 8) begin
            strbAddr0[strbCnt0] = WrAddr0;
            strbData0[strbCnt0] = WrData0;
            locNow0[strbCnt0]   = LocDout0;
            capIdx  = strbCnt0;
            capNext = 1'b1;
         end
         strbCnt0++;
      end
      if (WrStrb1)
         strbCnt1++;
      if (!SdaPadEn0 || !SdaPadEn1)
         driveCnt++;
   end

   // Hard time limit so the run always ends.
   initial begin
      #900us;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCnt++;
      if (actual !== expected) begin
         failCnt++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic waitQ();
      repeat (QTR) @(negedge clock);
   endtask

   // One SCL clock with the master presenting bitVal; returns the bus level
   // seen in the middle of the high phase.
   task automatic applyStimulus(input logic bitVal, output logic seen);
      sdaDrv = bitVal;
      waitQ();
      sclDrv = 1'b1;
      waitQ();
      #1 seen = sdaLine;
      waitQ();
      sclDrv = 1'b0;
      waitQ();
   endtask

   task automatic i2cStart();
      sdaDrv = 1'b1;
      waitQ();
      sclDrv = 1'b1;
      waitQ();
      sdaDrv = 1'b0;
      waitQ();
      sclDrv = 1'b0;
      waitQ();
   endtask

   task automatic i2cStop();
      sdaDrv = 1'b0;
      waitQ();
      sclDrv = 1'b1;
      waitQ();
      sdaDrv = 1'b1;
      waitQ();
   endtask

   task automatic i2cWriteByte(input logic [7:0] b, output logic ackSeen);
      logic dummy;
      for (int i = 7; i >= 0; i--)
         applyStimulus(b[i], dummy);
      applyStimulus(1'b1, ackSeen);
   endtask

   task automatic i2cReadByte(input logic masterNack, output logic [7:0] d);
      logic bitSeen;
      logic dummy;
      d = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b1, bitSeen);
         d[i] = bitSeen;
      end
      applyStimulus(masterNack, dummy);
   endtask

   initial begin
      $display("[TB] start");
      repeat (5) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rst SdaPadEn", SdaPadEn0, 1'b1);
      checkOutput("rst Busy", Busy0, 1'b0);
      checkOutput("rst WrStrb", WrStrb0, 1'b0);
      checkOutput("rst WrAddr", WrAddr0, 2'd0);
      checkOutput("rst WrData", WrData0, 8'h00);
      checkOutput("rst reg0", LocDout0, 8'h00);

      // Pointer/data alternating writes to dut0.
      LocAddr0 = 2'd1;
      i2cStart();
      i2cWriteByte(8'h20, ack); checkOutput("wr dev ack", ack, 1'b0);
      checkOutput("wr busy", Busy0, 1'b1);
      i2cWriteByte(8'h01, ack); checkOutput("wr mem1 ack", ack, 1'b0);
      i2cWriteByte(8'hA5, ack); checkOutput("wr A5 ack", ack, 1'b0);
      i2cWriteByte(8'h02, ack); checkOutput("wr mem2 ack", ack, 1'b0);
      i2cWriteByte(8'h5A, ack); checkOutput("wr 5A ack", ack, 1'b0);
      i2cStop();
      checkOutput("wr busy after stop", Busy0, 1'b0);
      checkOutput("wr strobe count", strbCnt0, 2);
      checkOutput("strb0 addr", strbAddr0[0], 2'd1);
      checkOutput("strb0 data", strbData0[0], 8'hA5);
      checkOutput("strb1 addr", strbAddr0[1], 2'd2);
      checkOutput("strb1 data", strbData0[1], 8'h5A);
      checkOutput("loc during strobe", locNow0[0], 8'h00);
      checkOutput("loc after strobe", locNext0[0], 8'hA5);
      @(negedge clock);
      checkOutput("reg1", LocDout0, 8'hA5);
      LocAddr0 = 2'd2;
      @(negedge clock);
      checkOutput("reg2", LocDout0, 8'h5A);

      // Pointer set, repeated START, two burst reads.
      i2cStart();
      i2cWriteByte(8'h20, ack); checkOutput("rd dev ack", ack, 1'b0);
      i2cWriteByte(8'h01, ack); checkOutput("rd mem ack", ack, 1'b0);
      i2cStart();
      i2cWriteByte(8'h21, ack); checkOutput("rd devR ack", ack, 1'b0);
      i2cReadByte(1'b0, rd);    checkOutput("rd byte1", rd, 8'hA5);
      i2cReadByte(1'b1, rd);    checkOutput("rd byte2", rd, 8'h5A);
      i2cStop();
      checkOutput("rd busy after stop", Busy0, 1'b0);

      // Pointer byte beyond the register file is refused.
      snap0 = strbCnt0;
      i2cStart();
      i2cWriteByte(8'h20, ack); checkOutput("oor dev ack", ack, 1'b0);
      i2cWriteByte(8'h10, ack); checkOutput("oor mem nack", ack, 1'b1);
      i2cWriteByte(8'h77, ack); checkOutput("oor data nack", ack, 1'b1);
      i2cStop();
      checkOutput("oor no strobe", strbCnt0 - snap0, 0);
      checkOutput("oor busy", Busy0, 1'b0);

      // Foreign address: no slave touches SDA.
      snapDrv = driveCnt;
      i2cStart();
      i2cWriteByte(8'h22, ack); checkOutput("foreign nack", ack, 1'b1);
      i2cWriteByte(8'h00, ack); checkOutput("foreign byte nack", ack, 1'b1);
      i2cStop();
      checkOutput("foreign no drive", driveCnt - snapDrv, 0);

      // Normal write afterwards; also sets up the wrap-around read.
      i2cStart();
      i2cWriteByte(8'h20, ack); checkOutput("wr2 dev ack", ack, 1'b0);
      i2cWriteByte(8'h00, ack); checkOutput("wr2 mem0 ack", ack, 1'b0);
      i2cWriteByte(8'h3C, ack); checkOutput("wr2 3C ack", ack, 1'b0);
      i2cWriteByte(8'h03, ack); checkOutput("wr2 mem3 ack", ack, 1'b0);
      i2cWriteByte(8'hC3, ack); checkOutput("wr2 C3 ack", ack, 1'b0);
      i2cStop();

      // Burst read from the last register wraps to register 0.
      i2cStart();
      i2cWriteByte(8'h20, ack); checkOutput("wrap dev ack", ack, 1'b0);
      i2cWriteByte(8'h03, ack); checkOutput("wrap mem ack", ack, 1'b0);
      i2cStart();
      i2cWriteByte(8'h21, ack); checkOutput("wrap devR ack", ack, 1'b0);
      i2cReadByte(1'b0, rd);    checkOutput("wrap byte reg3", rd, 8'hC3);
      i2cReadByte(1'b1, rd);    checkOutput("wrap byte reg0", rd, 8'h3C);
      i2cStop();

      // Reset while the slave is pulling SDA low for the address ACK.
      LocAddr0 = 2'd1;
      i2cStart();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] devByte;
         logic dummy;
         devByte = 8'h20;
         applyStimulus(devByte[i], dummy);
      end
      checkOutput("pre-reset ack drive", SdaPadEn0, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("reset SDA released", SdaPadEn0, 1'b1);
      checkOutput("reset busy", Busy0, 1'b0);
      checkOutput("reset reg1 cleared", LocDout0, 8'h00);
      reset = 1'b0;
      i2cStop();
      i2cStart();
      i2cWriteByte(8'h20, ack); checkOutput("post-rst dev ack", ack, 1'b0);
      i2cWriteByte(8'h02, ack); checkOutput("post-rst mem ack", ack, 1'b0);
      i2cWriteByte(8'h99, ack); checkOutput("post-rst data ack", ack, 1'b0);
      i2cStop();
      LocAddr0 = 2'd2;
      @(negedge clock);
      checkOutput("post-rst reg2", LocDout0, 8'h99);

      // dut1: burst write of three bytes from pointer 2 wraps to 0.
      snap0 = strbCnt0;
      snap1 = strbCnt1;
      i2cStart();
      i2cWriteByte(8'h44, ack); checkOutput("b dev ack", ack, 1'b0);
      i2cWriteByte(8'h02, ack); checkOutput("b mem ack", ack, 1'b0);
      i2cWriteByte(8'h11, ack); checkOutput("b d0 ack", ack, 1'b0);
      i2cWriteByte(8'h22, ack); checkOutput("b d1 ack", ack, 1'b0);
      i2cWriteByte(8'h33, ack); checkOutput("b d2 ack", ack, 1'b0);
      i2cStop();
      checkOutput("b dut1 strobes", strbCnt1 - snap1, 3);
      checkOutput("b dut0 strobes", strbCnt0 - snap0, 0);
      LocAddr1 = 2'd2; @(negedge clock); checkOutput("b reg2", LocDout1, 8'h11);
      LocAddr1 = 2'd3; @(negedge clock); checkOutput("b reg3", LocDout1, 8'h22);
      LocAddr1 = 2'd0; @(negedge clock); checkOutput("b reg0", LocDout1, 8'h33);
      LocAddr1 = 2'd1; @(negedge clock); checkOutput("b reg1", LocDout1, 8'h00);

      // dut1: fixed-pointer reads return the same register twice.
      i2cStart();
      i2cWriteByte(8'h44, ack); checkOutput("f dev ack", ack, 1'b0);
      i2cWriteByte(8'h03, ack); checkOutput("f mem ack", ack, 1'b0);
      i2cStart();
      i2cWriteByte(8'h45, ack); checkOutput("f devR ack", ack, 1'b0);
      i2cReadByte(1'b0, rd);    checkOutput("f byte1", rd, 8'h22);
      i2cReadByte(1'b1, rd);    checkOutput("f byte2", rd, 8'h22);
      i2cStop();
      checkOutput("f busy", Busy1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
